a2d_scan_intf: RTL and testbench

A2D_SCAN_INTF -- requirements
Module: a2d_scan_intf

---
 rtl/a2d_scan_intf.sv | 210 +++++++++++++++++++++
 tb/tb_a2d_scan_intf.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_scan_intf.sv
// Round-robin SPI A2D scanner: converts each enabled channel in turn and stores the result per channel.
// Optional build macro A2D_INVERT_EN stores the ones' complement of each read word.
module a2d_scan_intf #(
   parameter int NUM_CH   = 8,
   parameter int RES_W    = 12,
   parameter int SCLK_DIV = 32,
   localparam int RD_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              strt_scan,
   input  logic              cont,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic [RD_W-1:0]   rd_ch,
   output logic [RES_W-1:0]  rd_res,
   output logic [NUM_CH-1:0] res_vld,
   output logic              busy,
   output logic              scan_cmplt,
   output logic              a2d_SS_n,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO
);

   localparam int DIV_W = $clog2(SCLK_DIV);
   localparam logic [DIV_W-1:0] HALF_C  = DIV_W'(SCLK_DIV / 2);
   localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(SCLK_DIV / 2 - 1);
   localparam logic [DIV_W-1:0] FULL_M1 = DIV_W'(SCLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PICK  = 3'd1,
      FRONT = 3'd2,
      SHIFT = 3'd3,
      BACK  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          ptr_q, ptr_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [3:0]          bit_q, bit_d;
   logic [15:0]         word_q, word_d;
   logic [NUM_CH-1:0]   vld_q, vld_d;
   logic [RES_W-1:0]    res_q [NUM_CH];
   logic [RES_W-1:0]    res_d [NUM_CH];

   logic [NUM_CH-1:0]   shifted_s;
   logic [NUM_CH-1:0]   sel_s;
   logic [15:0]         cmd_s;
   logic [RES_W-1:0]    wr_data_s;

   // Remaining mask bits at/above the pointer tell PICK whether to convert, skip or finish.
   assign shifted_s = mask_q >> ptr_q;
   assign cmd_s     = {2'b00, ptr_q[2:0], 11'h000};

`ifdef A2D_INVERT_EN
   assign wr_data_s = ~word_q[RES_W-1:0];
`else
   assign wr_data_s = word_q[RES_W-1:0];
`endif

   // One-hot decode of the channel pointer for result and valid-flag writes
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         sel_s[i] = (ptr_q == 4'(i));
      end
   end

   // State and datapath registers; reset drops any partial frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 4'd0;
         mask_q  <= '0;
         div_q   <= '0;
         bit_q   <= 4'd0;
         word_q  <= 16'h0000;
         vld_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            res_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         mask_q  <= mask_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         vld_q   <= vld_d;
         res_q   <= res_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mask_d  = mask_q;
      div_d   = div_q;
      bit_d   = bit_q;
      word_d  = word_q;
      vld_d   = vld_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (strt_scan) begin
               mask_d  = ch_mask;
               vld_d   = '0;
               ptr_d   = 4'd0;
               state_d = PICK;
            end else begin
               state_d = IDLE;
            end
         end
         PICK: begin
            div_d = '0;
            bit_d = 4'd0;
            if (~|shifted_s) begin
               state_d = DONE;
            end else if (shifted_s[0]) begin
               state_d = FRONT;
            end else begin
               ptr_d = ptr_q + 4'd1;
            end
         end
         FRONT: begin
            if (div_q == HALF_M1) begin
               div_d   = '0;
               state_d = SHIFT;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         SHIFT: begin
            // The clk edge at the end of the low half is the SCLK rising edge.
            if (div_q == HALF_M1) begin
               word_d = {word_q[14:0], MISO};
            end else begin
               word_d = word_q;
            end
            if (div_q == FULL_M1) begin
               div_d = '0;
               if (bit_q == 4'd15) begin
                  state_d = BACK;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         BACK: begin
            if (div_q == HALF_M1) begin
               div_d = '0;
               vld_d = vld_q | sel_s;
               for (int i = 0; i < NUM_CH; i++) begin
                  res_d[i] = sel_s[i] ? wr_data_s : res_q[i];
               end
               ptr_d   = ptr_q + 4'd1;
               state_d = PICK;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DONE: begin
            if (cont) begin
               mask_d  = ch_mask;
               vld_d   = '0;
               ptr_d   = 4'd0;
               state_d = PICK;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from registered state, so reset forces the SPI idle levels at once
   always_comb begin
      a2d_SS_n   = 1'b1;
      SCLK       = 1'b1;
      MOSI       = 1'b0;
      busy       = (state_q != IDLE);
      scan_cmplt = (state_q == DONE);
      case (state_q)
         FRONT: a2d_SS_n = 1'b0;
         SHIFT: begin
            a2d_SS_n = 1'b0;
            SCLK     = (div_q >= HALF_C);
            MOSI     = cmd_s[4'd15 - bit_q];
         end
         BACK:    a2d_SS_n = 1'b0;
         default: a2d_SS_n = 1'b1;
      endcase
   end

   // Result read mux; addresses beyond the last channel read as zero
   always_comb begin
      rd_res = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         rd_res = rd_res | ({RES_W{rd_ch == RD_W'(i)}} & res_q[i]);
      end
   end

   assign res_vld = vld_q;

endmodule

// File: tb/tb_a2d_scan_intf.sv
// Directed bench for a2d_scan_intf with an SPI slave model; expectations follow the A2D_INVERT_EN build setting.
module tb_a2d_scan_intf;

   logic        clk;
   logic        rst_n;
   logic        strt_scan;
   logic        cont;
   logic [7:0]  ch_mask;
   logic [2:0]  rd_ch;
   logic [11:0] rd_res;
   logic [7:0]  res_vld;
   logic        busy;
   logic        scan_cmplt;
   logic        a2d_SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;

`ifdef A2D_INVERT_EN
   localparam logic [11:0] EXP_ABC = 12'h543;
   localparam logic [11:0] EXP_123 = 12'hEDC;
`else
   localparam logic [11:0] EXP_ABC = 12'hABC;
   localparam logic [11:0] EXP_123 = 12'h123;
`endif

   int errors = 0;
   int checks = 0;

   logic [15:0] resp_word;
   logic [15:0] mosi_sh;
   logic [15:0] miso_sh;
   int          rises;
   int          ss_falls;
   int          cmplt_cnt;
   logic [15:0] frame_cmd[$];
   int          frame_bits[$];

   a2d_scan_intf dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .strt_scan (strt_scan),
      .cont      (cont),
      .ch_mask   (ch_mask),
      .rd_ch     (rd_ch),
      .rd_res    (rd_res),
      .res_vld   (res_vld),
      .busy      (busy),
      .scan_cmplt(scan_cmplt),
      .a2d_SS_n  (a2d_SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SPI slave: preload the reply at frame start, capture MOSI and shift MISO on SCLK rising edges
   always @(negedge a2d_SS_n) begin
      ss_falls = ss_falls + 1;
      mosi_sh  = 16'h0000;
      rises    = 0;
      miso_sh  = resp_word;
      MISO     = resp_word[15];
   end

   always @(posedge SCLK) begin
      if (a2d_SS_n === 1'b0) begin
         mosi_sh = {mosi_sh[14:0], MOSI};
         rises   = rises + 1;
         miso_sh = {miso_sh[14:0], 1'b0};
         MISO    = miso_sh[15];
      end
   end

   always @(posedge a2d_SS_n) begin
      frame_cmd.push_back(mosi_sh);
      frame_bits.push_back(rises);
   end

   always @(posedge clk) begin
      if (scan_cmplt === 1'b1) cmplt_cnt = cmplt_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      frame_cmd.delete();
      frame_bits.delete();
      ss_falls  = 0;
      cmplt_cnt = 0;
   endtask

   task automatic start();
      @(negedge clk);
      strt_scan = 1'b1;
      @(negedge clk);
      strt_scan = 1'b0;
   endtask

   task automatic wait_cmplt(input int maxc, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < maxc; n++) begin
         @(negedge clk);
         if (scan_cmplt === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit          ok;
      bit          seen_low;
      logic [11:0] prev_res;

      rst_n = 1'b0; strt_scan = 1'b0; cont = 1'b0; ch_mask = 8'h00; rd_ch = 3'd0;
      resp_word = 16'h0ABC; MISO = 1'b0; rises = 0; ss_falls = 0; cmplt_cnt = 0;
      mosi_sh = 16'h0000; miso_sh = 16'h0000;
      repeat (3) @(negedge clk);
      chk("rst_ss_n", 32'(a2d_SS_n), 32'h1);
      chk("rst_sclk", 32'(SCLK), 32'h1);
      chk("rst_mosi", 32'(MOSI), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_cmplt", 32'(scan_cmplt), 32'h0);
      chk("rst_vld", 32'(res_vld), 32'h0);
      chk("rst_res", 32'(rd_res), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      clear_mon();

      // Full scan of all eight channels
      ch_mask = 8'hFF;
      start();
      wait_cmplt(6000, ok);
      chk("A_cmplt_seen", 32'(ok), 32'h1);
      @(negedge clk);
      chk("A_busy_after", 32'(busy), 32'h0);
      chk("A_frames", 32'(frame_cmd.size()), 32'd8);
      for (int i = 0; i < 8 && i < frame_cmd.size(); i++) begin
         chk($sformatf("A_cmd%0d", i), 32'(frame_cmd[i]), 32'(i) << 11);
         chk($sformatf("A_bits%0d", i), 32'(frame_bits[i]), 32'd16);
      end
      for (int i = 0; i < 8; i++) begin
         rd_ch = 3'(i);
         #1;
         chk($sformatf("A_res%0d", i), 32'(rd_res), 32'(EXP_ABC));
      end
      chk("A_vld", 32'(res_vld), 32'hFF);
      chk("A_cmplt_cnt", 32'(cmplt_cnt), 32'd1);

      // Sparse mask; the mid-scan ch_mask change must be ignored
      clear_mon();
      resp_word = 16'h0123;
      ch_mask = 8'hA4;
      start();
      ch_mask = 8'hFF;
      wait_cmplt(3000, ok);
      chk("B_cmplt_seen", 32'(ok), 32'h1);
      @(negedge clk);
      chk("B_frames", 32'(frame_cmd.size()), 32'd3);
      if (frame_cmd.size() == 3) begin
         chk("B_cmd0", 32'(frame_cmd[0]), 32'h1000);
         chk("B_cmd1", 32'(frame_cmd[1]), 32'h2800);
         chk("B_cmd2", 32'(frame_cmd[2]), 32'h3800);
      end
      chk("B_vld", 32'(res_vld), 32'hA4);
      rd_ch = 3'd5; #1;
      chk("B_res5", 32'(rd_res), 32'(EXP_123));
      rd_ch = 3'd0; #1;
      chk("B_res0_kept", 32'(rd_res), 32'(EXP_ABC));

      // Empty mask: completion two clocks after the start pulse, no SPI traffic
      clear_mon();
      ch_mask = 8'h00;
      @(negedge clk);
      strt_scan = 1'b1;
      @(negedge clk);
      strt_scan = 1'b0;
      chk("C_cmplt_early", 32'(scan_cmplt), 32'h0);
      chk("C_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("C_cmplt_2clk", 32'(scan_cmplt), 32'h1);
      @(negedge clk);
      chk("C_busy_after", 32'(busy), 32'h0);
      chk("C_ss_falls", 32'(ss_falls), 32'd0);

      // Continuous mode with an extra start pulse mid-frame
      clear_mon();
      resp_word = 16'h0ABC;
      ch_mask = 8'h01;
      cont = 1'b1;
      start();
      repeat (100) @(negedge clk);
      strt_scan = 1'b1;
      @(negedge clk);
      strt_scan = 1'b0;
      wait_cmplt(2000, ok);
      chk("D_cmplt1_seen", 32'(ok), 32'h1);
      @(negedge clk);
      chk("D_restart_busy", 32'(busy), 32'h1);
      chk("D_restart_cmplt", 32'(scan_cmplt), 32'h0);
      chk("D_restart_vld", 32'(res_vld), 32'h0);
      cont = 1'b0;
      wait_cmplt(2000, ok);
      chk("D_cmplt2_seen", 32'(ok), 32'h1);
      @(negedge clk);
      chk("D_busy_end", 32'(busy), 32'h0);
      chk("D_frames", 32'(frame_cmd.size()), 32'd2);
      for (int i = 0; i < frame_bits.size(); i++) begin
         chk($sformatf("D_bits%0d", i), 32'(frame_bits[i]), 32'd16);
      end
      chk("D_cmplt_cnt", 32'(cmplt_cnt), 32'd2);
      rd_ch = 3'd0; #1;
      chk("D_res0", 32'(rd_res), 32'(EXP_ABC));

      // Reset during the 9th SCLK of channel 3
      clear_mon();
      ch_mask = 8'hFF;
      start();
      ok = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (frame_cmd.size() == 3 && rises == 8 && SCLK === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("E_reached_9th", 32'(ok), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("E_ss_n_async", 32'(a2d_SS_n), 32'h1);
      chk("E_sclk_async", 32'(SCLK), 32'h1);
      chk("E_busy", 32'(busy), 32'h0);
      rd_ch = 3'd0; #1;
      chk("E_res0_zero", 32'(rd_res), 32'h0);
      rd_ch = 3'd3; #1;
      chk("E_res3_zero", 32'(rd_res), 32'h0);
      chk("E_vld_zero", 32'(res_vld), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_mon();

      // Scan after reset; read of channel 3 across its write shows old then new
      ch_mask = 8'h08;
      rd_ch = 3'd3;
      start();
      seen_low = 1'b0;
      prev_res = 12'hFFF;
      ok = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (a2d_SS_n === 1'b0) begin
            seen_low = 1'b1;
            prev_res = rd_res;
         end else if (seen_low) begin
            ok = 1'b1;
            break;
         end
      end
      chk("F_frame_end", 32'(ok), 32'h1);
      chk("F_res_old", 32'(prev_res), 32'h0);
      chk("F_res_new", 32'(rd_res), 32'(EXP_ABC));
      wait_cmplt(100, ok);
      chk("F_cmplt_seen", 32'(ok), 32'h1);
      chk("F_frames", 32'(frame_cmd.size()), 32'd1);
      if (frame_cmd.size() == 1) begin
         chk("F_cmd", 32'(frame_cmd[0]), 32'h1800);
      end
      chk("F_vld", 32'(res_vld), 32'h08);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
